// File: rtl/pixel_pkg.sv
// Shared pixel-stream types for the temporal IIR smoother.
//   Contents: default geometry localparams, the IIR FSM state enum,
//   the pipeline stage payload struct and the IIR update step.
package pixel_pkg;

    localparam int unsigned PIX_DW    = 8;
    localparam int unsigned PIX_NPIX  = 768;
    localparam int unsigned PIX_K_MAX = 4;
    localparam int unsigned PIX_AW    = $clog2(PIX_NPIX);
    localparam int unsigned PIX_KW    = $clog2(PIX_K_MAX + 1);
    localparam int          PIX_MAX   = (1 << PIX_DW) - 1;

    typedef enum logic [1:0] {IDLE, SEED, RUN} iir_state_t;

    // One pixel in flight; mode is the FSM view latched when the pixel entered S0
    typedef struct packed {
        logic              valid;
        logic [PIX_AW-1:0] addr;
        logic [PIX_DW-1:0] data;
        iir_state_t        mode;
    } pix_stage_t;

    // y = old + round((x - old) / 2^k), saturated to the pixel range
    function automatic logic [PIX_DW-1:0] iir_step(
        input logic [PIX_DW-1:0] old,
        input logic [PIX_DW-1:0] x,
        input logic [PIX_KW-1:0] k
    );
        int d;
        int y;
        int ki;
        ki = int'(k);
        if (ki == 0) begin
            return x;
        end
        d = int'(x) - int'(old);
        // arithmetic shift floors, so the +half bias gives round-half-up
        y = int'(old) + ((d + (1 << (ki - 1))) >>> ki);
        if (y < 0) begin
            return '0;
        end
        if (y > PIX_MAX) begin
            return '1;
        end
        return PIX_DW'(y);
    endfunction

endpackage

// File: rtl/mu_ram_1r1w.sv
// Simple dual-port RAM, one write port and one registered read port.
//   i_clk           clock
//   we/waddr/wdata  write port
//   re/raddr        read request; rdata valid one cycle later
//   rdata           read data (old contents on a same-address collision)
module mu_ram_1r1w #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 10
) (
    input  logic          i_clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/temporal_iir_filter.sv
// Per-pixel temporal IIR smoother for the thermal pixel stream.
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_start               restart: drop the seed, re-seed on the next frame
//   i_bypass              pass raw data, leave the RAM untouched
//   i_k                   smoothing shift, clamped to K_MAX, latched at addr 0
//   i_valid/i_addr/i_data input pixel
//   o_valid/o_addr/o_data output pixel, 2 cycles after input
//   o_seeded              high while the filter is running on a seeded RAM
module temporal_iir_filter
    import pixel_pkg::*;
#(
    parameter  int unsigned DW    = PIX_DW,
    parameter  int unsigned NPIX  = PIX_NPIX,
    parameter  int unsigned K_MAX = PIX_K_MAX,
    localparam int unsigned AW    = $clog2(NPIX),
    localparam int unsigned KW    = $clog2(K_MAX + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_bypass,
    input  logic [KW-1:0] i_k,
    input  logic          i_valid,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_data,
    output logic          o_seeded
);

    iir_state_t    state;
    iir_state_t    state_nx;
    iir_state_t    s0_mode;
    logic          seeded;
    logic [KW-1:0] k_frame;
    logic [KW-1:0] k_in;
    pix_stage_t    s1;
    pix_stage_t    s2;
    logic          fwd_far;
    logic [DW-1:0] fwd_far_data;
    logic [DW-1:0] ram_rdata;
    logic [DW-1:0] old_val;
    logic [DW-1:0] result;
    logic          in_range;
    logic          is_first;
    logic          is_last;
    logic          wr_en;

    assign in_range = i_valid && (32'(i_addr) < NPIX);
    assign is_first = (i_addr == '0);
    assign is_last  = (i_addr == AW'(NPIX - 1));
    assign k_in     = (32'(i_k) > K_MAX) ? KW'(K_MAX) : i_k;
    assign wr_en    = s2.valid && (s2.mode != IDLE);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= IDLE;
            seeded <= 1'b0;
        end else begin
            state  <= state_nx;
            seeded <= (state_nx == RUN);
        end
    end

    // Next state: frame tracking ignores bypass, restart overrides everything
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_range && is_first) state_nx = SEED;
            SEED:    if (in_range && is_last)  state_nx = RUN;
            RUN:     state_nx = RUN;
            default: state_nx = IDLE;
        endcase
        if (i_start) begin
            state_nx = IDLE;
        end
    end

    // Mode tag for the pixel entering S0; bypass behaves like IDLE for that pixel
    always_comb begin
        s0_mode = state;
        if ((state == IDLE) && in_range && is_first) begin
            s0_mode = SEED;
        end
        if (i_start || i_bypass) begin
            s0_mode = IDLE;
        end
    end

    mu_ram_1r1w #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .i_clk (i_clk),
        .we    (wr_en),
        .waddr (s2.addr),
        .wdata (s2.data),
        .re    (in_range),
        .raddr (i_addr),
        .rdata (ram_rdata)
    );

    // S1 update: newest in-flight write wins over the RAM read data
    always_comb begin
        old_val = ram_rdata;
        if (fwd_far) begin
            old_val = fwd_far_data;
        end
        if (wr_en && (s2.addr == s1.addr)) begin
            old_val = s2.data;
        end
        result = (s1.mode == RUN) ? iir_step(old_val, s1.data, k_frame) : s1.data;
    end

    // Pipeline; fwd_far covers the write that lands while S0 reads the same address
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1           <= '0;
            s2           <= '0;
            fwd_far      <= 1'b0;
            fwd_far_data <= '0;
            k_frame      <= '0;
        end else begin
            s1           <= '{valid: in_range, addr: i_addr, data: i_data, mode: s0_mode};
            s2           <= '{valid: s1.valid, addr: s1.addr, data: result, mode: s1.mode};
            fwd_far      <= wr_en && (s2.addr == i_addr);
            fwd_far_data <= s2.data;
            if (in_range && is_first) begin
                k_frame <= k_in;
            end
        end
    end

    assign o_valid  = s2.valid;
    assign o_addr   = s2.addr;
    assign o_data   = s2.data;
    assign o_seeded = seeded;

endmodule

// File: tb/tb_temporal_iir_filter.sv
// Directed bench for temporal_iir_filter.
//   Each cycle drives one pixel (or idle) on the falling edge together with the
//   hand-computed expected output, and compares the output of the pixel driven
//   two cycles earlier.
module tb_temporal_iir_filter
    import pixel_pkg::*;
;

    localparam int unsigned DW   = PIX_DW;
    localparam int unsigned NPIX = PIX_NPIX;
    localparam int unsigned AW   = PIX_AW;
    localparam int unsigned KW   = PIX_KW;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_start;
    logic          i_bypass;
    logic [KW-1:0] i_k;
    logic          i_valid;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_data;
    logic          o_valid;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_data;
    logic          o_seeded;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic e1_v = 1'b0;
    logic e2_v = 1'b0;
    int   e1_d = 0;
    int   e2_d = 0;
    int   e1_a = 0;
    int   e2_a = 0;

    temporal_iir_filter dut (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_start  (i_start),
        .i_bypass (i_bypass),
        .i_k      (i_k),
        .i_valid  (i_valid),
        .i_addr   (i_addr),
        .i_data   (i_data),
        .o_valid  (o_valid),
        .o_addr   (o_addr),
        .o_data   (o_data),
        .o_seeded (o_seeded)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One cycle: check the pixel from two cycles ago, then drive the next one
    task automatic px(input logic vld, input int a, input int x, input logic ev, input int ey,
                      input logic st = 1'b0, input logic byp = 1'b0);
        @(negedge clk);
        check($sformatf("o_valid@%0d", e2_a), 32'(o_valid), 32'(e2_v));
        if (e2_v) begin
            check($sformatf("o_data@%0d", e2_a), 32'(o_data), 32'(e2_d));
            check($sformatf("o_addr@%0d", e2_a), 32'(o_addr), 32'(e2_a));
        end
        e2_v = e1_v;
        e2_d = e1_d;
        e2_a = e1_a;
        e1_v = ev;
        e1_d = ey;
        e1_a = a;
        i_valid  = vld;
        i_addr   = AW'(a);
        i_data   = DW'(x);
        i_start  = st;
        i_bypass = byp;
    endtask

    task automatic idle_cycle();
        px(1'b0, 0, 0, 1'b0, 0);
    endtask

    initial begin
        int x;
        int ey;
        i_rst    = 1'b1;
        i_start  = 1'b0;
        i_bypass = 1'b0;
        i_k      = KW'(2);
        i_valid  = 1'b0;
        i_addr   = '0;
        i_data   = '0;
        repeat (3) @(negedge clk);
        check("rst o_valid", 32'(o_valid), 0);
        check("rst o_data", 32'(o_data), 0);
        check("rst o_addr", 32'(o_addr), 0);
        check("rst o_seeded", 32'(o_seeded), 0);
        i_rst = 1'b0;

        check("iir_step up k2", 32'(iir_step(8'd100, 8'd200, 3'd2)), 125);
        check("iir_step down k2", 32'(iir_step(8'd200, 8'd100, 3'd2)), 175);

        // Seed frame: raw pass-through, RAM = 100
        for (int a = 0; a < NPIX; a++) begin
            px(1'b1, a, 100, 1'b1, 100);
            if (a == 400) check("seeded mid seed", 32'(o_seeded), 0);
        end
        idle_cycle();
        check("seeded after seed", 32'(o_seeded), 1);

        // Frame A, k=2; i_k drops to 0 at addr 300 but this frame keeps k=2
        for (int a = 0; a < NPIX; a++) begin
            x = 100; ey = 100;
            if (a == 0)   begin x = 200; ey = 125; end
            if (a == 300) begin x = 200; ey = 125; i_k = KW'(0); end
            px(1'b1, a, x, 1'b1, ey);
        end

        // Frame B, k=0: y = x; mid-frame i_k=2 is ignored
        for (int a = 0; a < NPIX; a++) begin
            x = 100; ey = 100;
            if (a == 0)   begin x = 200; ey = 200; end
            if (a == 1)   begin x = 200; ey = 200; end
            if (a == 5)   begin x = 0;   ey = 0;   end
            if (a == 10)  i_k = KW'(2);
            if (a == 300) begin x = 50;  ey = 50;  end
            px(1'b1, a, x, 1'b1, ey);
        end

        // Frame C, k=2: old=200, x=100 -> 175; i_k=1 queued for next frame
        for (int a = 0; a < NPIX; a++) begin
            x = 100; ey = 100;
            if (a == 0)   begin x = 100; ey = 175; end
            if (a == 1)   begin x = 200; ey = 200; end
            if (a == 5)   begin x = 0;   ey = 0;   end
            if (a == 10)  i_k = KW'(1);
            if (a == 300) begin x = 50;  ey = 50;  end
            px(1'b1, a, x, 1'b1, ey);
        end

        // Frame D, k=1: back-to-back and distance-2 hazards on addr 5
        for (int a = 0; a < NPIX; a++) begin
            x = 100; ey = 100;
            if (a == 0)   begin x = 175; ey = 175; end
            if (a == 1)   begin x = 200; ey = 200; end
            if (a == 300) begin x = 50;  ey = 50;  end
            if (a == 5) begin
                px(1'b1, 5, 255, 1'b1, 128);
                px(1'b1, 5, 255, 1'b1, 192);
            end else if (a == 6) begin
                px(1'b1, 6, 100, 1'b1, 100);
                px(1'b1, 5, 255, 1'b1, 224);
            end else begin
                px(1'b1, a, x, 1'b1, ey);
            end
        end

        // Frame E, k=1: bypass at addr 2, out-of-range addr 800
        for (int a = 0; a < NPIX; a++) begin
            x = 100; ey = 100;
            if (a == 0)   begin x = 175; ey = 175; end
            if (a == 1)   begin x = 200; ey = 200; end
            if (a == 5)   begin x = 224; ey = 224; end
            if (a == 300) begin x = 50;  ey = 50;  end
            if (a == 2) begin
                px(1'b1, 2, 7, 1'b1, 7, 1'b0, 1'b1);
                px(1'b1, 800, 55, 1'b0, 0);
            end else begin
                px(1'b1, a, x, 1'b1, ey);
            end
        end

        // Frame F, k=1: addr 2 still 100 in RAM; restart at addr 400
        for (int a = 0; a < NPIX; a++) begin
            x = 100; ey = 100;
            if (a == 0)   begin x = 175; ey = 175; end
            if (a == 1)   begin x = 200; ey = 200; end
            if (a == 5)   begin x = 224; ey = 224; end
            if (a == 300) begin x = 50;  ey = 50;  end
            if (a == 398 || a == 399) begin x = 20; ey = 60; end
            if (a >= 400) begin x = 10;  ey = 10;  end
            px(1'b1, a, x, 1'b1, ey, (a == 400) ? 1'b1 : 1'b0);
            if (a == 399) check("seeded before restart", 32'(o_seeded), 1);
            if (a == 401) check("seeded after restart", 32'(o_seeded), 0);
        end

        // Frame G: restart coincides with addr 0, whole frame stays pass-through
        for (int a = 0; a < NPIX; a++) begin
            x = (a == 0) ? 50 : 30;
            px(1'b1, a, x, 1'b1, x, (a == 0) ? 1'b1 : 1'b0);
        end
        idle_cycle();
        check("seeded after start@0", 32'(o_seeded), 0);

        // Frame H: re-seed; i_k=7 queued (clamps to 4 next frame)
        for (int a = 0; a < NPIX; a++) begin
            x = (a == 0) ? 50 : 30;
            if (a == 10) i_k = KW'(7);
            px(1'b1, a, x, 1'b1, x);
            if (a == 400) check("seeded mid reseed", 32'(o_seeded), 0);
        end
        idle_cycle();
        check("seeded after reseed", 32'(o_seeded), 1);

        // Frame I (partial), k clamped to 4
        px(1'b1, 0, 60, 1'b1, 51);
        px(1'b1, 1, 250, 1'b1, 44);
        px(1'b1, 2, 0, 1'b1, 28);
        px(1'b1, 3, 30, 1'b1, 30);
        idle_cycle();
        idle_cycle();
        idle_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
